// File: rtl/mult_share_arbiter_if.sv
// rtl/mult_share_arbiter_if.sv - requester and multiplier bus of the shared-multiplier arbiter
interface mult_share_arbiter_if #(
   parameter int NREQ = 4
);
   logic [NREQ-1:0]   req;
   logic [8*NREQ-1:0] op_a;
   logic [8*NREQ-1:0] op_b;
   logic [NREQ-1:0]   grant;
   logic [NREQ-1:0]   done;
   logic [15:0]       result;
   logic              err;
   logic              busy;
   logic              mul_start;
   logic [7:0]        mul_a;
   logic [7:0]        mul_b;
   logic              mul_ready;
   logic [15:0]       mul_product;

   modport slave (
      input  req, op_a, op_b, mul_ready, mul_product,
      output grant, done, result, err, busy, mul_start, mul_a, mul_b
   );

   modport master (
      output req, op_a, op_b, mul_ready, mul_product,
      input  grant, done, result, err, busy, mul_start, mul_a, mul_b
   );
endinterface

// File: rtl/mult_share_arbiter.sv
// rtl/mult_share_arbiter.sv - round-robin sharing of one serial multiplier with watchdog abort
module mult_share_arbiter #(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 16,
   parameter int CW      = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   mult_share_arbiter_if.slave  bus
);
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic {IDLE, WAIT} state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   ptr_q, ptr_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [NREQ-1:0] grant_q, grant_d;
   logic [NREQ-1:0] done_q, done_d;
   logic [15:0]     result_q, result_d;
   logic            err_q, err_d;
   logic            busy_q, busy_d;
   logic            start_q, start_d;
   logic [7:0]      a_q, a_d;
   logic [7:0]      b_q, b_d;

   logic            found;
   logic [IW-1:0]   win;
   logic [IW:0]     cand;

   // Rotating priority: first request at or above the pointer, wrapping.
   always_comb begin
      found = 1'b0;
      win   = '0;
      cand  = '0;
      for (int off = 0; off < NREQ; off++) begin
         cand = {1'b0, ptr_q} + (IW+1)'(off);
         if (cand >= (IW+1)'(NREQ)) cand = cand - (IW+1)'(NREQ);
         if (!found && bus.req[cand[IW-1:0]]) begin
            found = 1'b1;
            win   = cand[IW-1:0];
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      grant_d  = '0;
      done_d   = '0;
      result_d = result_q;
      err_d    = 1'b0;
      busy_d   = busy_q;
      start_d  = 1'b0;
      a_d      = a_q;
      b_d      = b_q;
      case (state_q)
         IDLE: begin
            if (found) begin
               idx_d        = win;
               a_d          = bus.op_a[{win, 3'b000} +: 8];
               b_d          = bus.op_b[{win, 3'b000} +: 8];
               start_d      = 1'b1;
               grant_d[win] = 1'b1;
               busy_d       = 1'b1;
               cnt_d        = '0;
               ptr_d        = (win == IW'(NREQ-1)) ? '0 : win + 1'b1;
               state_d      = WAIT;
            end
         end
         WAIT: begin
            cnt_d = cnt_q + 1'b1;
            // Ready seen in the first WAIT cycle may be left over from the previous product.
            if (cnt_q != '0 && bus.mul_ready) begin
               result_d      = bus.mul_product;
               done_d[idx_q] = 1'b1;
               busy_d        = 1'b0;
               state_d       = IDLE;
            end else if (cnt_q == CW'(TIMEOUT-1)) begin
               result_d      = '0;
               done_d[idx_q] = 1'b1;
               err_d         = 1'b1;
               busy_d        = 1'b0;
               state_d       = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         ptr_q    <= '0;
         idx_q    <= '0;
         cnt_q    <= '0;
         grant_q  <= '0;
         done_q   <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
         busy_q   <= 1'b0;
         start_q  <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         grant_q  <= grant_d;
         done_q   <= done_d;
         result_q <= result_d;
         err_q    <= err_d;
         busy_q   <= busy_d;
         start_q  <= start_d;
         a_q      <= a_d;
         b_q      <= b_d;
      end
   end

   assign bus.grant     = grant_q;
   assign bus.done      = done_q;
   assign bus.result    = result_q;
   assign bus.err       = err_q;
   assign bus.busy      = busy_q;
   assign bus.mul_start = start_q;
   assign bus.mul_a     = a_q;
   assign bus.mul_b     = b_q;
endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb/tb_mult_share_arbiter.sv - randomized bench for mult_share_arbiter against a transaction model
module tb_mult_share_arbiter;
   localparam int NREQ    = 4;
   localparam int TIMEOUT = 16;
   localparam int CW      = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mult_share_arbiter_if #(.NREQ(NREQ)) bus ();

   mult_share_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int ref_ptr  = 0;
   int lat      = 0;
   bit hang     = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int pick(input logic [NREQ-1:0] r, input int p);
      int j;
      for (int k = 0; k < NREQ; k++) begin
         j = (p + k) % NREQ;
         if (r[j]) return j;
      end
      return 0;
   endfunction

   function automatic logic [8*NREQ-1:0] rand_ops();
      logic [8*NREQ-1:0] v;
      for (int i = 0; i < NREQ; i++) v[8*i +: 8] = 8'($urandom);
      return v;
   endfunction

   // Serial multiplier stand-in: ready stays high (stale) until the cycle after the next start.
   initial begin
      logic [15:0] p;
      bus.mul_ready   = 1'b0;
      bus.mul_product = '0;
      forever begin
         @(posedge clk); #1;
         if (bus.mul_start === 1'b1) begin
            p = 16'(bus.mul_a) * 16'(bus.mul_b);
            @(posedge clk); #1;
            bus.mul_ready   = 1'b0;
            bus.mul_product = 16'($urandom);
            if (!hang) begin
               repeat (lat) begin @(posedge clk); #1; end
               bus.mul_ready   = 1'b1;
               bus.mul_product = p;
            end
         end
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      ref_ptr = 0;
   endtask

   task automatic do_op(input logic [NREQ-1:0] r, input logic [8*NREQ-1:0] a,
                        input logic [8*NREQ-1:0] b, input int l, input bit h, input bit drop);
      int w;
      int n;
      logic [7:0] ea, eb;
      logic [15:0] er;
      logic [NREQ-1:0] oh;
      lat = l;
      hang = h;
      bus.req  = r;
      bus.op_a = a;
      bus.op_b = b;
      w  = pick(r, ref_ptr);
      ea = a[8*w +: 8];
      eb = b[8*w +: 8];
      er = h ? 16'h0000 : 16'(ea) * 16'(eb);
      oh = '0;
      oh[w] = 1'b1;
      @(posedge clk); #1;
      check_eq("grant", bus.grant, oh);
      check_eq("mul_start", bus.mul_start, 1);
      check_eq("mul_a", bus.mul_a, ea);
      check_eq("mul_b", bus.mul_b, eb);
      check_eq("busy_set", bus.busy, 1);
      ref_ptr = (w + 1) % NREQ;
      bus.op_a = rand_ops();
      bus.op_b = rand_ops();
      if (drop) bus.req = '0;
      n = 0;
      while (n < TIMEOUT + 4) begin
         @(posedge clk); #1;
         n++;
         if (n == 1) begin
            check_eq("grant_pulse", bus.grant, 0);
            check_eq("start_pulse", bus.mul_start, 0);
         end
         if (bus.done != '0) break;
      end
      check_eq("done_latency", n, h ? TIMEOUT : l + 2);
      check_eq("done", bus.done, oh);
      check_eq("result", bus.result, er);
      check_eq("err", bus.err, h);
      check_eq("busy_clr", bus.busy, 0);
      check_eq("mul_a_stable", bus.mul_a, ea);
   endtask

   initial begin
      logic [8*NREQ-1:0] a, b;
      logic [NREQ-1:0] r;
      bit seen;
      bus.req  = '0;
      bus.op_a = '0;
      bus.op_b = '0;
      do_reset();
      check_eq("rst_grant", bus.grant, 0);
      check_eq("rst_done", bus.done, 0);
      check_eq("rst_result", bus.result, 0);
      check_eq("rst_err", bus.err, 0);
      check_eq("rst_busy", bus.busy, 0);
      check_eq("rst_start", bus.mul_start, 0);
      check_eq("rst_mul_a", bus.mul_a, 0);
      check_eq("rst_mul_b", bus.mul_b, 0);
      repeat (3) begin @(posedge clk); #1; end
      check_eq("idle_grant", bus.grant, 0);
      check_eq("idle_busy", bus.busy, 0);

      a = '0; b = '0;
      a[7:0] = 8'd3; b[7:0] = 8'd5;
      do_op(4'b0001, a, b, 3, 1'b0, 1'b1);
      check_eq("single_result", bus.result, 16'd15);

      do_reset();
      for (int i = 0; i < NREQ; i++) begin
         a[8*i +: 8] = 8'(i + 1);
         b[8*i +: 8] = 8'd10;
      end
      for (int i = 0; i < NREQ; i++) begin
         do_op(4'b1111, a, b, i, 1'b0, 1'b0);
         check_eq("all_req_result", bus.result, 32'((i + 1) * 10));
      end

      do_op(4'b0100, rand_ops(), rand_ops(), 2, 1'b0, 1'b0);
      do_op(4'b1010, rand_ops(), rand_ops(), 1, 1'b0, 1'b0);
      check_eq("fair_first", bus.done, 4'b1000);
      do_op(4'b1010, rand_ops(), rand_ops(), 4, 1'b0, 1'b0);
      check_eq("fair_second", bus.done, 4'b0010);

      a = '1; b = '1;
      do_op(4'b0001, a, b, 5, 1'b0, 1'b1);
      check_eq("ff_result", bus.result, 16'hFE01);

      do_op(4'b0010, rand_ops(), rand_ops(), 0, 1'b1, 1'b1);
      do_op(4'b0010, rand_ops(), rand_ops(), 0, 1'b0, 1'b1);

      // Abort an operation in flight with a one-cycle reset.
      hang = 1'b1;
      bus.req  = 4'b0001;
      bus.op_a = rand_ops();
      bus.op_b = rand_ops();
      @(posedge clk); #1;
      check_eq("rstw_grant", bus.grant, 4'b0001);
      bus.req = '0;
      repeat (3) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      ref_ptr = 0;
      check_eq("rstw_busy", bus.busy, 0);
      check_eq("rstw_done", bus.done, 0);
      check_eq("rstw_result", bus.result, 0);
      check_eq("rstw_mul_a", bus.mul_a, 0);
      seen = 1'b0;
      repeat (TIMEOUT + 4) begin
         @(posedge clk); #1;
         if (bus.done != '0 || bus.err) seen = 1'b1;
      end
      check_eq("rstw_no_done", seen, 0);
      do_op(4'b1001, rand_ops(), rand_ops(), 2, 1'b0, 1'b1);
      check_eq("rstw_ptr", bus.done, 4'b0001);

      for (int t = 0; t < 40; t++) begin
         r = 4'($urandom_range(1, 15));
         do_op(r, rand_ops(), rand_ops(), $urandom_range(0, 5),
               ($urandom_range(0, 7) == 0), 1'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
